// File: rtl/gpio_port_pkg.sv
// Shared constants for the gpio_port block: register map and legal parameter ranges.
package gpio_port_pkg;

  localparam logic [1:0] GPIO_ADDR_OUT = 2'd0;
  localparam logic [1:0] GPIO_ADDR_DIR = 2'd1;
  localparam logic [1:0] GPIO_ADDR_IN  = 2'd2;
  localparam logic [1:0] GPIO_ADDR_IRQ = 2'd3;

  localparam int GPIO_BUS_WIDTH = 32;
  localparam int GPIO_WIDTH_MIN = 1;
  localparam int GPIO_WIDTH_MAX = 32;
  localparam int GPIO_SYNC_MIN  = 2;
  localparam int GPIO_SYNC_MAX  = 4;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-wide, SYNC_STAGES-deep input synchroniser; every stage resets to 0.
module gpio_sync
  import gpio_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (SYNC_STAGES < GPIO_SYNC_MIN || SYNC_STAGES > GPIO_SYNC_MAX) begin : g_bad_depth
    $error("gpio_sync: SYNC_STAGES out of range");
  end

  logic [WIDTH-1:0] stage_r [SYNC_STAGES];

  // Shift chain: stage 0 captures the pin, later stages follow one edge behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Parametrised GPIO port on the registered peripheral bus (two-cycle read latency).
// Optional rising-edge interrupt unit is built when GPIO_PORT_IRQ_EN is defined.
module gpio_port
  import gpio_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [1:0]       address,
  input  logic [31:0]      dataIn,
  output logic             readValid,
  output logic [31:0]      dataOut,
  input  logic [WIDTH-1:0] ioIn,
  output logic [WIDTH-1:0] ioOut,
  output logic [WIDTH-1:0] ioOe,
  output logic             irq
);

  if (WIDTH < GPIO_WIDTH_MIN || WIDTH > GPIO_WIDTH_MAX) begin : g_bad_width
    $error("gpio_port: WIDTH out of range");
  end

  if (WIDTH < GPIO_BUS_WIDTH) begin : g_unused_hi
    logic unused_hi_s;
    assign unused_hi_s = |dataIn[GPIO_BUS_WIDTH-1:WIDTH];
  end

  logic             read_r;
  logic             write_r;
  logic [1:0]       addr_r;
  logic [WIDTH-1:0] wdata_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] status_s;
  logic [31:0]      rd_word_s;

  // Request stage: control bits reset, write data is a plain pipeline flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_r  <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= 2'd0;
    end else begin
      read_r  <= read;
      write_r <= write;
      addr_r  <= address;
    end
  end

  // Write data capture, deliberately without reset.
  always_ff @(posedge clk) begin
    wdata_r <= dataIn[WIDTH-1:0];
  end

  // OUT and DIR registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r <= '0;
      dir_r <= '0;
    end else begin
      if (write_r && (addr_r == GPIO_ADDR_OUT)) begin
        out_r <= wdata_r;
      end
      if (write_r && (addr_r == GPIO_ADDR_DIR)) begin
        dir_r <= wdata_r;
      end
    end
  end

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (ioIn),
    .q     (in_s)
  );

`ifdef GPIO_PORT_IRQ_EN
  logic [WIDTH-1:0] hist_r;
  logic [WIDTH-1:0] status_r;
  logic             irq_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] clr_s;

  // Rising-edge detect and W1C mask for the status register.
  always_comb begin
    rise_s = in_s & ~hist_r;
    if (write_r && (addr_r == GPIO_ADDR_IRQ)) begin
      clr_s = wdata_r;
    end else begin
      clr_s = '0;
    end
  end

  // Status update: the set term is OR-ed last so a same-cycle edge beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_r   <= '0;
      status_r <= '0;
      irq_r    <= 1'b0;
    end else begin
      hist_r   <= in_s;
      status_r <= (status_r & ~clr_s) | rise_s;
      irq_r    <= |status_r;
    end
  end

  assign status_s = status_r;
  assign irq      = irq_r;
`else
  assign status_s = '0;
  assign irq      = 1'b0;
`endif

  // Read mux from the registered address; sees pre-write register contents.
  always_comb begin
    rd_word_s = 32'd0;
    case (addr_r)
      GPIO_ADDR_OUT: rd_word_s[WIDTH-1:0] = out_r;
      GPIO_ADDR_DIR: rd_word_s[WIDTH-1:0] = dir_r;
      GPIO_ADDR_IN:  rd_word_s[WIDTH-1:0] = in_s;
      GPIO_ADDR_IRQ: rd_word_s[WIDTH-1:0] = status_s;
      default:       rd_word_s = 32'd0;
    endcase
  end

  // Read response: one-cycle valid pulse, data held until the next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readValid <= 1'b0;
      dataOut   <= 32'd0;
    end else begin
      readValid <= read_r;
      if (read_r) begin
        dataOut <= rd_word_s;
      end
    end
  end

  assign ioOut = out_r;
  assign ioOe  = dir_r;

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port: an 8-bit and a 32-bit instance on a shared bus.
module tb_gpio_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] dataIn;
  logic        readValid8, readValid32;
  logic [31:0] dataOut8, dataOut32;
  logic [7:0]  ioIn8, ioOut8, ioOe8;
  logic [31:0] ioIn32, ioOut32, ioOe32;
  logic        irq8, irq32;
  logic [31:0] d8, d32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .dataIn(dataIn), .readValid(readValid8), .dataOut(dataOut8),
    .ioIn(ioIn8), .ioOut(ioOut8), .ioOe(ioOe8), .irq(irq8)
  );

  gpio_port #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .dataIn(dataIn), .readValid(readValid32), .dataOut(dataOut32),
    .ioIn(ioIn32), .ioOut(ioOut32), .ioOe(ioOe32), .irq(irq32)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    dataIn  = d;
    write   = 1'b1;
    @(posedge clk); #1;
    write   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag,
                          output logic [31:0] r8, output logic [31:0] r32);
    address = a;
    read    = 1'b1;
    @(posedge clk); #1;
    read    = 1'b0;
    check_eq({tag, "_rv_early"}, {31'd0, readValid8}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_rv8"}, {31'd0, readValid8}, 32'd1);
    check_eq({tag, "_rv32"}, {31'd0, readValid32}, 32'd1);
    r8  = dataOut8;
    r32 = dataOut32;
    @(posedge clk); #1;
    check_eq({tag, "_rv_drop"}, {31'd0, readValid8}, 32'd0);
    check_eq({tag, "_hold"}, dataOut8, r8);
  endtask

  initial begin
    reset   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    address = 2'd0;
    dataIn  = 32'd0;
    ioIn8   = 8'($urandom);
    ioIn32  = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ioout", {24'd0, ioOut8}, 32'h0000_0000);
    check_eq("rst_iooe", {24'd0, ioOe8}, 32'h0000_0000);
    check_eq("rst_irq", {31'd0, irq8}, 32'd0);
    check_eq("rst_rv", {31'd0, readValid8}, 32'd0);
    check_eq("rst_dout", dataOut8, 32'h0000_0000);
    check_eq("rst_ioout32", ioOut32, 32'h0000_0000);
    ioIn8  = 8'h00;
    ioIn32 = 32'h0000_0000;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_read(2'd3, "rst_status", d8, d32);
    check_eq("rst_status_val", d8, 32'h0000_0000);

    // Write / readback
    bus_write(2'd0, 32'h0000_00A5);
    check_eq("out_a5", {24'd0, ioOut8}, 32'h0000_00A5);
    check_eq("out_a5_w32", ioOut32, 32'h0000_00A5);
    address = 2'd1;
    dataIn  = 32'h0000_000F;
    write   = 1'b1;
    @(posedge clk); #1;
    write   = 1'b0;
    check_eq("dir_before", {24'd0, ioOe8}, 32'h0000_0000);
    @(posedge clk); #1;
    check_eq("dir_after", {24'd0, ioOe8}, 32'h0000_000F);
    bus_read(2'd0, "rd_out", d8, d32);
    check_eq("rd_out_val", d8, 32'h0000_00A5);
    bus_read(2'd1, "rd_dir", d8, d32);
    check_eq("rd_dir_val", d8, 32'h0000_000F);

    // Input synchroniser
    ioIn8 = 8'h3C;
    bus_read(2'd2, "in_early", d8, d32);
    check_eq("in_early_val", d8, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    bus_read(2'd2, "in_late", d8, d32);
    check_eq("in_late_val", d8, 32'h0000_003C);
    bus_write(2'd2, 32'h0000_00FF);
    bus_read(2'd2, "in_ro", d8, d32);
    check_eq("in_ro_val", d8, 32'h0000_003C);
    check_eq("in_ro_out", {24'd0, ioOut8}, 32'h0000_00A5);
    check_eq("in_ro_dir", {24'd0, ioOe8}, 32'h0000_000F);

    // Simultaneous read and write of OUT
    bus_write(2'd0, 32'h0000_0011);
    address = 2'd0;
    dataIn  = 32'h0000_0022;
    read    = 1'b1;
    write   = 1'b1;
    @(posedge clk); #1;
    read    = 1'b0;
    write   = 1'b0;
    @(posedge clk); #1;
    check_eq("rw_rv", {31'd0, readValid8}, 32'd1);
    check_eq("rw_old", dataOut8, 32'h0000_0011);
    check_eq("rw_new", {24'd0, ioOut8}, 32'h0000_0022);

`ifdef GPIO_PORT_IRQ_EN
    // Interrupt unit
    ioIn8 = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    bus_write(2'd3, 32'h0000_00FF);
    bus_read(2'd3, "irq_clr", d8, d32);
    check_eq("irq_clr_val", d8, 32'h0000_0000);
    check_eq("irq_clr_line", {31'd0, irq8}, 32'd0);
    ioIn8 = 8'h10;
    repeat (4) @(posedge clk);
    #1;
    check_eq("irq_rise", {31'd0, irq8}, 32'd1);
    bus_read(2'd3, "irq_stat", d8, d32);
    check_eq("irq_stat_val", d8, 32'h0000_0010);
    bus_write(2'd3, 32'h0000_0001);
    bus_read(2'd3, "irq_w0", d8, d32);
    check_eq("irq_w0_val", d8, 32'h0000_0010);
    address = 2'd3;
    dataIn  = 32'h0000_0010;
    write   = 1'b1;
    @(posedge clk); #1;
    write   = 1'b0;
    @(posedge clk); #1;
    check_eq("irq_hold", {31'd0, irq8}, 32'd1);
    @(posedge clk); #1;
    check_eq("irq_fall", {31'd0, irq8}, 32'd0);
    bus_read(2'd3, "irq_w1c", d8, d32);
    check_eq("irq_w1c_val", d8, 32'h0000_0000);

    // Set beats clear on bit 2
    ioIn8 = 8'h14;
    @(posedge clk); #1;
    address = 2'd3;
    dataIn  = 32'h0000_0004;
    write   = 1'b1;
    @(posedge clk); #1;
    write   = 1'b0;
    @(posedge clk); #1;
    bus_read(2'd3, "irq_coll", d8, d32);
    check_eq("irq_coll_val", d8, 32'h0000_0004);
`else
    bus_read(2'd3, "noirq_rd", d8, d32);
    check_eq("noirq_rd_val", d8, 32'h0000_0000);
    ioIn8 = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    check_eq("noirq_line", {31'd0, irq8}, 32'd0);
    bus_write(2'd3, 32'h0000_00FF);
    bus_read(2'd3, "noirq_wr", d8, d32);
    check_eq("noirq_wr_val", d8, 32'h0000_0000);
    check_eq("noirq_out", {24'd0, ioOut8}, 32'h0000_0022);
`endif

    // Reset in the middle of a read
    address = 2'd0;
    read    = 1'b1;
    @(posedge clk); #1;
    read    = 1'b0;
    reset   = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_rv8", {31'd0, readValid8}, 32'd0);
    check_eq("mid_rst_rv32", {31'd0, readValid32}, 32'd0);
    check_eq("mid_rst_dout", dataOut8, 32'h0000_0000);
    check_eq("mid_rst_out", {24'd0, ioOut8}, 32'h0000_0000);
    @(posedge clk); #1;
    check_eq("mid_rst_rv_late", {31'd0, readValid8}, 32'd0);
    ioIn8 = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 32-bit instance full width
    bus_write(2'd0, 32'hDEAD_BEEF);
    check_eq("w32_out", ioOut32, 32'hDEAD_BEEF);
    check_eq("w8_trunc", {24'd0, ioOut8}, 32'h0000_00EF);
    bus_read(2'd0, "w32_rd", d8, d32);
    check_eq("w32_rd_val", d32, 32'hDEAD_BEEF);
    check_eq("w8_rd_val", d8, 32'h0000_00EF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
